prbs_multi_checker: RTL
=======================

// Module: prbs_multi_checker
//
// PURPOSE
// Parallel PRBS checker for the PRBS7/9/15/23/31 patterns, WIDTH bits per clock. It sits after a SERDES or loopback
// receive datapath and self-synchronises to the incoming stream. A lock state machine controls the checker; once
// locked, it counts bit errors exactly using a free-running local LFSR. Bit/polynomial conventions match our PRBS31
// generator: PRBS-N with taps (N,M) produces b[n] = b[n-N] ^ b[n-M].
//
// PARAMETERS
// WIDTH          32  bits per word; legal range 31..256
// MSB_FIRST      0   0: din[0] is the earliest bit of the word; 1: din[WIDTH-1] is the earliest bit
// LOCK_COUNT     16  consecutive clean, nonzero words in SEARCH required to lock
// LOSS_COUNT     4   consecutive bad words (popcount(err) > WIDTH/4) in LOCKED required to drop lock
// CNT_WIDTH      32  width of the saturating error and word counters
//
// PORTS
// clk            in   1          clock
// rst_n          in   1          asynchronous active-low reset
// poly_sel       in   3          0=PRBS7(7,6) 1=PRBS9(9,5) 2=PRBS15(15,14) 3=PRBS23(23,18) 4..7=PRBS31(31,28)
// din_valid      in   1          din holds a word to check this cycle
// din            in   WIDTH      received data word
// clear_count    in   1          synchronous clear of bit_err_count and word_count
// locked         out  1          checker is in LOCKED
// err_word       out  1          one-cycle pulse: previous valid word had >=1 bit error while LOCKED
// bit_err_count  out  CNT_WIDTH  saturating count of bit errors seen while LOCKED
// word_count     out  CNT_WIDTH  saturating count of valid words checked while LOCKED
//
// BEHAVIOUR
// - Reset (async, rst_n=0): state=SEARCH; 31-bit history=0; lock/loss counters=0; locked=0; err_word=0;
//   bit_err_count=0; word_count=0; poly_q=0.
// - Idle cycles (din_valid=0) change no state; err_word=0 on the next cycle.
// - Expected bits: bit i of the word (in time order) is expected = h[i-N] ^ h[i-M], where h is the bit sequence
//   formed by the history followed by this word. err = din ^ expected (per bit, in time order).
// - SEARCH: h uses received bits, so the check is self-synchronising. The history is loaded with the last 31 received
//   bits. A word is clean when err==0 and din!=0. A clean word increments the lock counter; any other word clears it.
//   When the counter reaches LOCK_COUNT, the state moves to LOCKED on that edge. The history then holds the last 31
//   received bits, which seed the local LFSR. Counters do not change in SEARCH.
// - An all-zero input word never counts toward lock. All-zero data therefore never locks.
// - LOCKED: the expected bits come from the local LFSR advanced by WIDTH bits per valid word. Received bits are not
//   fed back, so a single flipped input bit costs exactly 1 error.
//   - word_count increments by 1 per valid word.
//   - bit_err_count increments by popcount(err).
//   - Both counters saturate at all-ones.
//   - err_word = (err!=0).
//   A word with popcount(err) > WIDTH/4 increments the loss counter; any other word clears it. At LOSS_COUNT the
//   state moves to SEARCH, the lock counter is cleared, and that word's errors are still counted.
// - Latency: all outputs are registered. A word presented at edge k is reflected in locked, err_word and the counters
//   after edge k+1.
// - poly_sel is sampled into poly_q on each valid word. If poly_sel != poly_q, the word is checked with the new taps,
//   the state is forced to SEARCH, and the lock counter is cleared.
// - clear_count has priority. Both counters become 0 and the same-cycle word's contribution is discarded. err_word
//   and the FSM are unaffected.
// - Popcount is WIDTH-wide, summed into a $clog2(WIDTH+1)-bit value, and added with saturation in CNT_WIDTH.
// - History width is always 31 bits. Shorter polynomials use only the low taps. Unused history bits still shift.
//
// TESTING
// 1. Reset; PRBS31 (seed 1, WIDTH=32) on consecutive valid words -> locked=1 no later than word LOCK_COUNT+2;
//    bit_err_count=0 thereafter.
// 2. While locked, flip din[5] in one word -> bit_err_count +1 exactly; err_word pulses for 1 cycle; locked stays 1.
// 3. din=0 for 100 words -> locked stays 0; counters stay 0.
// 4. Locked on PRBS31, switch source to PRBS7 with poly_sel unchanged -> locked drops after LOSS_COUNT=4 words.
//    Set poly_sel=0 -> relock within LOCK_COUNT+2 words.
// 5. CNT_WIDTH=4, inject 20 bit errors -> bit_err_count=15 (saturated). clear_count together with an errored word
//    -> counter=0.
// 6. Deassert rst_n mid-lock with din_valid=1 -> locked=0 and counters=0 immediately (async); relock after release.

Source files
------------

// File: rtl/prbs_multi_checker.sv
// Parallel self-synchronising PRBS7/9/15/23/31 checker, WIDTH bits per clock.
// A SEARCH/LOCKED state machine gates exact, saturating bit-error and word counting.
module prbs_multi_checker #(
    parameter int WIDTH      = 32,
    parameter int MSB_FIRST  = 0,
    parameter int LOCK_COUNT = 16,
    parameter int LOSS_COUNT = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           poly_sel,
    input  logic                 din_valid,
    input  logic [WIDTH-1:0]     din,
    input  logic                 clear_count,
    output logic                 locked,
    output logic                 err_word,
    output logic [CNT_WIDTH-1:0] bit_err_count,
    output logic [CNT_WIDTH-1:0] word_count
);

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int LK_W  = $clog2(LOCK_COUNT + 1);
    localparam int LS_W  = $clog2(LOSS_COUNT + 1);
    localparam int SUM_W = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;

    localparam logic [0:0]           ST_SEARCH = 1'b0;
    localparam logic [0:0]           ST_LOCKED = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [PC_W-1:0]      LOSS_THR  = PC_W'(WIDTH / 4);
    localparam logic [LK_W-1:0]      LOCK_LAST = LK_W'(LOCK_COUNT - 1);
    localparam logic [LS_W-1:0]      LOSS_LAST = LS_W'(LOSS_COUNT - 1);

    function automatic logic [PC_W-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + PC_W'(v[i]);
        return c;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [PC_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(CNT_MAX)) return CNT_MAX;
        return s[CNT_WIDTH-1:0];
    endfunction

    logic [0:0]           r_state;
    logic [30:0]          r_hist;
    logic [2:0]           r_poly;
    logic [LK_W-1:0]      r_lock_cnt;
    logic [LS_W-1:0]      r_loss_cnt;
    logic                 r_err_word;
    logic [CNT_WIDTH-1:0] r_bec;
    logic [CNT_WIDTH-1:0] r_wc;

    logic [WIDTH-1:0]     w_din_t;
    logic [WIDTH-1:0]     w_exp;
    logic [WIDTH-1:0]     w_err;
    logic [30:0]          w_hist_nxt;
    logic [PC_W-1:0]      w_pop;

    always_comb begin
        w_din_t = '0;
        for (int i = 0; i < WIDTH; i++)
            w_din_t[i] = (MSB_FIRST != 0) ? din[WIDTH-1-i] : din[i];
    end

    // v_seq[30:0] is the history (bit 30 newest); v_seq[31+i] is word bit i in time order.
    always_comb begin : gen_exp
        logic [WIDTH+30:0] v_seq;
        v_seq       = '0;
        v_seq[30:0] = r_hist;
        w_exp       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (poly_sel)
                3'd0:    w_exp[i] = v_seq[i+24] ^ v_seq[i+25];
                3'd1:    w_exp[i] = v_seq[i+22] ^ v_seq[i+26];
                3'd2:    w_exp[i] = v_seq[i+16] ^ v_seq[i+17];
                3'd3:    w_exp[i] = v_seq[i+8]  ^ v_seq[i+13];
                default: w_exp[i] = v_seq[i]    ^ v_seq[i+3];
            endcase
            v_seq[31+i] = (r_state == ST_LOCKED) ? w_exp[i] : w_din_t[i];
        end
        w_hist_nxt = v_seq[WIDTH+30:WIDTH];
    end

    assign w_err = w_din_t ^ w_exp;
    assign w_pop = popcnt(w_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_SEARCH;
            r_hist     <= '0;
            r_poly     <= '0;
            r_lock_cnt <= '0;
            r_loss_cnt <= '0;
            r_err_word <= 1'b0;
        end else begin
            r_err_word <= 1'b0;
            if (din_valid) begin
                r_poly <= poly_sel;
                r_hist <= w_hist_nxt;
                if (r_state == ST_LOCKED) begin
                    r_err_word <= |w_err;
                    if (w_pop > LOSS_THR) begin
                        if (r_loss_cnt == LOSS_LAST) begin
                            r_state    <= ST_SEARCH;
                            r_loss_cnt <= '0;
                            r_lock_cnt <= '0;
                        end else begin
                            r_loss_cnt <= r_loss_cnt + LS_W'(1);
                        end
                    end else begin
                        r_loss_cnt <= '0;
                    end
                end else begin
                    if ((w_err == '0) && (din != '0)) begin
                        if (r_lock_cnt == LOCK_LAST) begin
                            r_state    <= ST_LOCKED;
                            r_lock_cnt <= '0;
                            r_loss_cnt <= '0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + LK_W'(1);
                        end
                    end else begin
                        r_lock_cnt <= '0;
                    end
                end
                // A tap change invalidates any partial or full lock.
                if (poly_sel != r_poly) begin
                    r_state    <= ST_SEARCH;
                    r_lock_cnt <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bec <= '0;
            r_wc  <= '0;
        end else if (clear_count) begin
            r_bec <= '0;
            r_wc  <= '0;
        end else if (din_valid && (r_state == ST_LOCKED)) begin
            r_bec <= sat_add(r_bec, w_pop);
            r_wc  <= sat_add(r_wc, PC_W'(1));
        end
    end

    assign locked        = (r_state == ST_LOCKED);
    assign err_word      = r_err_word;
    assign bit_err_count = r_bec;
    assign word_count    = r_wc;

endmodule
